// File: rtl/lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor
//
// Measures the period of an upstream pseudo-random generator. On an accepted
// start the current generator value is captured as a reference, then every
// generator shift step is counted until the reference value reappears. The
// measurement also ends early when the generator is stuck at all-zeros
// (lockup), or when no recurrence is seen within MAX_PERIOD steps (timeout).
//
// Parameters
//   WIDTH       generator state width
//   MAX_PERIOD  step limit before timeout, must be <= 2**WIDTH - 1
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   start    in   begin a measurement (level-sampled, only acted on when idle)
//   sh_en    in   shift-enable strobe shared with the generator
//   q_in     in   generator state
//   busy     out  measurement in progress or result being presented
//   done     out  single-cycle pulse, results valid
//   period   out  steps to recurrence, 0 on lockup or timeout
//   lockup   out  generator seen at all-zeros during the measurement
//   timeout  out  no recurrence within MAX_PERIOD steps
//   ref_val  out  captured reference value
// -----------------------------------------------------------------------------
module lfsr_period_monitor #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned MAX_PERIOD = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sh_en,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             lockup,
    output logic             timeout,
    output logic [WIDTH-1:0] ref_val
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MAX_PERIOD);

    state_t           r_state;
    logic             r_step_d;
    logic [WIDTH:0]   r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   r_period;
    logic             r_lockup;
    logic             r_timeout;
    logic [WIDTH-1:0] r_ref;

    logic [WIDTH:0]   w_cnt_next;
    logic             w_q_zero;
    logic             w_q_match;
    logic             w_at_limit;

    // The generator moves on the edge where sh_en is high, so the new value
    // is visible in the cycle after; r_step_d marks that cycle.
    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        w_q_zero   = (q_in == '0);
        w_q_match  = (q_in == r_ref);
        w_at_limit = (w_cnt_next == LP_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_step_d  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_period  <= '0;
            r_lockup  <= 1'b0;
            r_timeout <= 1'b0;
            r_ref     <= '0;
        end else begin
            r_step_d <= sh_en;
            r_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        // A step in this cycle produced the reference itself,
                        // so it is deliberately not counted.
                        r_ref     <= q_in;
                        r_cnt     <= '0;
                        r_period  <= '0;
                        r_lockup  <= 1'b0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                        if (w_q_zero) begin
                            r_lockup <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_COUNT;
                        end
                    end
                end

                ST_COUNT: begin
                    r_busy <= 1'b1;
                    if (r_step_d) begin
                        r_cnt <= w_cnt_next;
                        // Lockup beats a match; a match on the final allowed
                        // step still reports a valid period, not a timeout.
                        if (w_q_zero) begin
                            r_lockup <= 1'b1;
                            r_period <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_q_match) begin
                            r_period <= w_cnt_next;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_at_limit) begin
                            r_timeout <= 1'b1;
                            r_period  <= '0;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign period  = r_period;
    assign lockup  = r_lockup;
    assign timeout = r_timeout;
    assign ref_val = r_ref;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_monitor
//
// Drives lfsr_period_monitor from a behavioural generator (maximal-length
// taps 10,7, constant, or alternating patterns) and checks the reported
// results and timing against hand-computed values.
//
// Cycle numbering: start is asserted in cycle 0 and sampled on edge 0. With
// sh_en high in cycle c the generator moves on edge c, and the monitor
// evaluates that step on edge c+1. done is seen in the cycle after the
// terminating edge; the latency recorded is that cycle's number.
// -----------------------------------------------------------------------------
module tb_lfsr_period_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sh_en;
    logic [9:0]  q_in;
    logic        busy;
    logic        done;
    logic [10:0] period;
    logic        lockup;
    logic        timeout;
    logic [9:0]  ref_val;

    int total;
    int bad;

    // generator model state
    int          mode;   // 0 lfsr, 1 constant, 2 alternating 001/002
    int          zstep;  // alternating mode: step that yields 0 (0 = never)
    int          sidx;   // generator steps taken
    int          div;    // sh_en high when cycle % div == 0

    lfsr_period_monitor #(
        .WIDTH      (10),
        .MAX_PERIOD (1023)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sh_en   (sh_en),
        .q_in    (q_in),
        .busy    (busy),
        .done    (done),
        .period  (period),
        .lockup  (lockup),
        .timeout (timeout),
        .ref_val (ref_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         mode;
        logic [9:0] seed;
        int         div;
        int         zstep;
        int         exp_period;
        int         exp_lockup;
        int         exp_timeout;
        int         exp_lat;
    } vec_t;

    function automatic logic [9:0] gen(input logic [9:0] q, input int s);
        logic [9:0] r;
        case (mode)
            0:       r = {q[8:0], q[9] ^ q[6]};
            1:       r = q;
            default: r = (s == zstep) ? 10'h000 : ((s % 2 == 1) ? 10'h001 : 10'h002);
        endcase
        return r;
    endfunction

    function automatic logic pat(input int c);
        return (c % div) == 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // one clock edge; the generator moves if sh_en was high at that edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (sh_en) begin
            sidx++;
            q_in = gen(q_in, sidx);
        end
    endtask

    task automatic idle(input int n);
        sh_en = 1'b0;
        start = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // start a measurement and wait for done; returns the cycle done was seen
    task automatic run_to_done(input string nm, input int limit,
                               input int restart_at, output int cyc);
        cyc   = 0;
        sidx  = 0;
        sh_en = pat(0);
        start = 1'b1;
        tick();
        cyc   = 1;
        start = 1'b0;
        sh_en = pat(1);
        chk({nm, ".busy_after_start"}, busy, 1);
        while (!done && cyc < limit) begin
            start = (restart_at > 0 && cyc >= restart_at && cyc < restart_at + 3);
            tick();
            cyc++;
            sh_en = pat(cyc);
        end
        start = 1'b0;
        if (!done) chk({nm, ".done_within_bound"}, 0, 1);
    endtask

    vec_t vecs[7];

    initial begin
        int cyc;
        bit saw_done;

        total = 0;
        bad   = 0;
        mode  = 1;
        zstep = 0;
        sidx  = 0;
        div   = 1;
        rst_n = 1'b0;
        start = 1'b0;
        sh_en = 1'b0;
        q_in  = 10'h26E;

        vecs[0] = '{"lfsr_cont",   0, 10'h26E, 1, 0, 1023, 0, 0, 1024};
        vecs[1] = '{"lfsr_div4",   0, 10'h26E, 4, 0, 1023, 0, 0, 4090};
        vecs[2] = '{"zero_start",  1, 10'h000, 1, 0,    0, 1, 0,    1};
        vecs[3] = '{"alt_timeout", 2, 10'h3FF, 1, 0,    0, 0, 1, 1024};
        vecs[4] = '{"const_155",   1, 10'h155, 1, 0,    1, 0, 0,    2};
        vecs[5] = '{"alt_zero5",   2, 10'h3FF, 1, 5,    0, 1, 0,    6};
        vecs[6] = '{"lfsr_div2",   0, 10'h001, 2, 0, 1023, 0, 0, 2046};

        // reset state
        repeat (3) tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.period", period, 0);
        chk("rst.lockup", lockup, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.ref_val", ref_val, 0);
        rst_n = 1'b1;
        idle(2);

        // table-driven measurements
        foreach (vecs[k]) begin
            idle(2);
            mode  = vecs[k].mode;
            zstep = vecs[k].zstep;
            div   = vecs[k].div;
            q_in  = vecs[k].seed;
            run_to_done(vecs[k].name, 6000, 0, cyc);
            if (done) begin
                chk({vecs[k].name, ".latency"}, cyc, vecs[k].exp_lat);
                chk({vecs[k].name, ".period"}, period, vecs[k].exp_period);
                chk({vecs[k].name, ".lockup"}, lockup, vecs[k].exp_lockup);
                chk({vecs[k].name, ".timeout"}, timeout, vecs[k].exp_timeout);
                chk({vecs[k].name, ".ref_val"}, ref_val, vecs[k].seed);
                chk({vecs[k].name, ".busy_in_done"}, busy, 1);
                sh_en = 1'b0;
                tick();
                chk({vecs[k].name, ".done_one_cycle"}, done, 0);
                chk({vecs[k].name, ".busy_cleared"}, busy, 0);
                chk({vecs[k].name, ".period_held"}, period, vecs[k].exp_period);
            end
        end

        // reset in the middle of a measurement
        idle(2);
        mode = 0; div = 1; q_in = 10'h26E;
        sidx = 0;
        sh_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 500) begin
            tick();
            cyc++;
        end
        chk("midrst.busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.period", period, 0);
        chk("midrst.ref_val", ref_val, 0);
        chk("midrst.lockup_timeout", {lockup, timeout}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrst.no_done_after", saw_done, 0);

        // start re-pulsed mid-measurement is ignored; immediate restart after done
        idle(2);
        mode = 0; div = 1; q_in = 10'h26E;
        run_to_done("overlap", 6000, 100, cyc);
        if (done) begin
            chk("overlap.latency", cyc, 1024);
            chk("overlap.period", period, 1023);
            chk("overlap.ref_val", ref_val, 10'h26E);
            sh_en = 1'b0;
            tick();
            chk("overlap.idle_after_done", busy, 0);
            mode  = 1;
            q_in  = 10'h000;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("restart.done", done, 1);
            chk("restart.lockup", lockup, 1);
            chk("restart.ref_val", ref_val, 0);
            chk("restart.period", period, 0);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
